// File: rtl/spi_flash_pkg.sv
// Shared opcodes, command encodings and sequencer states
// for the serial-flash command sequencer.
package spi_flash_pkg;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_PROG  = 2'd1,
    OP_ERASE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_GAP,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_POLL,
    S_FIN
  } state_e;

endpackage

// File: rtl/spi_flash_ctrl.sv
// Serial-flash command sequencer: READ, PAGE PROGRAM and
// SECTOR ERASE on top of a byte-level SPI master.
module spi_flash_ctrl
  import spi_flash_pkg::*;
#(
  parameter int CS_GAP   = 8,
  parameter int POLL_MAX = 2**20,
  parameter int ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [8:0]        cmd_len,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              op_done,
  output logic              op_err,
  output logic              spi_req,
  output logic [7:0]        spi_tx,
  input  logic [7:0]        spi_rx,
  input  logic              spi_done
);

  localparam int GW = $clog2(CS_GAP);
  localparam int PW = $clog2(POLL_MAX);

  state_e            st, st_d, nx, nx_d;
  op_e               op, op_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [23:0]       a24;
  logic [8:0]        len, len_d, cnt, cnt_d;
  logic [GW-1:0]     gcnt, gcnt_d;
  logic [PW-1:0]     pcnt, pcnt_d;
  logic              err, err_d, ld;
  logic              req_d, rdv_d, ack_d;
  logic              done_d, oerr_d;
  logic [7:0]        tx_d, rdd_d;
  logic              dn;

  assign a24       = 24'(addr);
  assign dn        = spi_done & spi_req;
  assign cmd_ready = (st == S_IDLE);
  assign busy      = (st != S_IDLE);

  always_comb begin
    st_d   = st;
    nx_d   = nx;
    op_d   = op;
    addr_d = addr;
    len_d  = len;
    cnt_d  = cnt;
    gcnt_d = gcnt;
    pcnt_d = pcnt;
    err_d  = err;
    req_d  = spi_req;
    tx_d   = spi_tx;
    rdd_d  = rd_data;
    rdv_d  = 1'b0;
    ack_d  = 1'b0;
    // program byte arrives one cycle after wr_ack
    if (ld) tx_d = wr_data;
    unique case (st)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          addr_d = cmd_addr;
          len_d  = (cmd_len == 9'd0) ? 9'd256 : cmd_len;
          cnt_d  = '0;
          pcnt_d = '0;
          err_d  = 1'b0;
          case (op_e'(cmd_op))
            OP_READ: begin
              st_d = S_CMD;
              tx_d = OPC_READ;
            end
            OP_PROG, OP_ERASE: begin
              st_d = S_WREN;
              tx_d = OPC_WREN;
            end
            default: begin
              st_d  = S_FIN;
              err_d = 1'b1;
            end
          endcase
        end
      end
      S_WREN: begin
        if (!spi_req) begin
          req_d = 1'b1;
        end else if (dn) begin
          req_d  = 1'b0;
          st_d   = S_GAP;
          nx_d   = S_CMD;
          gcnt_d = '0;
          tx_d   = (op == OP_PROG) ? OPC_PP : OPC_SE;
        end
      end
      S_GAP: begin
        if (gcnt == GW'(CS_GAP - 1)) begin
          st_d  = nx;
          req_d = 1'b1;
          cnt_d = 9'd1;
        end else begin
          gcnt_d = gcnt + 1'b1;
        end
      end
      S_CMD: begin
        if (!spi_req) begin
          req_d = 1'b1;
        end else if (dn) begin
          tx_d  = a24[23:16];
          cnt_d = 9'd2;
          st_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (dn) begin
          if (cnt != 9'd0) begin
            tx_d  = (cnt == 9'd2) ? a24[15:8] : a24[7:0];
            cnt_d = cnt - 9'd1;
          end else if (op == OP_ERASE) begin
            req_d  = 1'b0;
            st_d   = S_GAP;
            nx_d   = S_POLL;
            gcnt_d = '0;
            tx_d   = OPC_RDSR;
          end else begin
            st_d  = S_DATA;
            cnt_d = len;
            tx_d  = 8'h00;
            ack_d = (op == OP_PROG);
          end
        end
      end
      S_DATA: begin
        if (dn) begin
          cnt_d = cnt - 9'd1;
          if (op == OP_READ) begin
            rdd_d = spi_rx;
            rdv_d = 1'b1;
          end
          if (cnt == 9'd1) begin
            req_d = 1'b0;
            if (op == OP_READ) begin
              st_d = S_FIN;
            end else begin
              st_d   = S_GAP;
              nx_d   = S_POLL;
              gcnt_d = '0;
              tx_d   = OPC_RDSR;
            end
          end else begin
            ack_d = (op == OP_PROG);
          end
        end
      end
      S_POLL: begin
        // cnt=1 marks the RDSR opcode byte still in flight
        if (dn) begin
          if (cnt != 9'd0) begin
            cnt_d = '0;
            tx_d  = 8'h00;
          end else if (!spi_rx[0]) begin
            req_d = 1'b0;
            st_d  = S_FIN;
          end else if (pcnt == PW'(POLL_MAX - 1)) begin
            req_d = 1'b0;
            st_d  = S_FIN;
            err_d = 1'b1;
          end else begin
            pcnt_d = pcnt + 1'b1;
          end
        end
      end
      S_FIN: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    done_d = (st_d == S_FIN);
    oerr_d = done_d & err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      nx       <= S_IDLE;
      op       <= OP_READ;
      addr     <= '0;
      len      <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      pcnt     <= '0;
      err      <= 1'b0;
      ld       <= 1'b0;
      spi_req  <= 1'b0;
      spi_tx   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      op_done  <= 1'b0;
      op_err   <= 1'b0;
    end else begin
      st       <= st_d;
      nx       <= nx_d;
      op       <= op_d;
      addr     <= addr_d;
      len      <= len_d;
      cnt      <= cnt_d;
      gcnt     <= gcnt_d;
      pcnt     <= pcnt_d;
      err      <= err_d;
      ld       <= wr_ack;
      spi_req  <= req_d;
      spi_tx   <= tx_d;
      rd_data  <= rdd_d;
      rd_valid <= rdv_d;
      wr_ack   <= ack_d;
      op_done  <= done_d;
      op_err   <= oerr_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Bench for spi_flash_ctrl: byte-level SPI master model,
// behavioural flash and a scoreboard of expected bytes.
module tb_spi_flash_ctrl;
  import spi_flash_pkg::*;

  localparam int CS_GAP   = 8;
  localparam int POLL_MAX = 16;
  localparam int K        = 8;
  localparam int SAMP     = 4;
  localparam int TMO      = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [23:0] cmd_addr = '0;
  logic [8:0]  cmd_len = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        op_done;
  logic        op_err;
  logic        spi_req;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx = '0;
  logic        spi_done = 1'b0;

  always #5 clk = ~clk;

  spi_flash_ctrl #(
    .CS_GAP  (CS_GAP),
    .POLL_MAX(POLL_MAX),
    .ADDR_W  (24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .op_done  (op_done),
    .op_err   (op_err),
    .spi_req  (spi_req),
    .spi_tx   (spi_tx),
    .spi_rx   (spi_rx),
    .spi_done (spi_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  logic [7:0] mem [int];
  logic [7:0] pbuf [$];
  logic [7:0] exp_mosi [$];
  logic [7:0] exp_rd [$];
  int         exp_flen [$];
  logic [7:0] wq [$];
  logic [7:0] fcmd = '0;
  logic [7:0] resp = 8'hFF;
  int  bidx = 0, fa = 0, mcnt = 0;
  int  busy_left = 0, busy_cfg = 0;
  int  gcount = 0, rd_cnt = 0;
  bit  stuck = 0, wel = 0, prev_req = 0;
  bit  sb_off = 0, req_seen = 0;

  function automatic logic [7:0] fget(input int a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  // byte master: one byte per K cycles while req is held
  always @(posedge clk) begin
    spi_done <= 1'b0;
    if (!spi_req) begin
      mcnt <= 0;
    end else if (mcnt == K - 1) begin
      mcnt     <= 0;
      spi_done <= 1'b1;
      spi_rx   <= resp;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (wr_ack) begin
      #1 wr_data = (wq.size() > 0) ? wq.pop_front() : 8'h00;
    end
  end

  task automatic byte_in(input logic [7:0] b);
    if (!sb_off) begin
      if (exp_mosi.size() == 0) chk("mosi_extra", {24'd0, b}, 32'h100);
      else chk("mosi", b, exp_mosi.pop_front());
    end
    if (bidx == 0) begin
      fcmd = b;
      fa   = 0;
    end else if (bidx <= 3) begin
      fa = (fa << 8) | int'(b);
    end
    resp = 8'hFF;
    case (fcmd)
      OPC_READ: if (bidx >= 4) resp = fget((fa + bidx - 4) & 'hFFFFFF);
      OPC_PP:   if (bidx >= 4) pbuf.push_back(b);
      OPC_RDSR: if (bidx >= 1) begin
        resp = {7'd0, busy_left > 0};
        if (busy_left > 0 && !stuck) busy_left--;
      end
      default: ;
    endcase
    bidx++;
  endtask

  task automatic frame_end();
    int base;
    if (!sb_off) begin
      if (exp_flen.size() == 0) chk("frame_extra", bidx, 32'hFFFF);
      else chk("flen", bidx, exp_flen.pop_front());
    end
    case (fcmd)
      OPC_WREN: if (bidx == 1) wel = 1;
      OPC_PP: if (wel && bidx >= 4) begin
        for (int i = 0; i < pbuf.size(); i++)
          mem[(fa & 'hFFFF00) | ((fa + i) & 'hFF)] = pbuf[i];
        wel = 0;
        busy_left = busy_cfg;
      end
      OPC_SE: if (wel && bidx == 4) begin
        base = fa & 'hFFF000;
        for (int i = 0; i < 4096; i++)
          if (mem.exists(base + i)) mem.delete(base + i);
        wel = 0;
        busy_left = busy_cfg;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (spi_req) req_seen = 1;
    if (prev_req && !spi_req) frame_end();
    if (!prev_req && spi_req) begin
      bidx = 0;
      fcmd = '0;
      pbuf.delete();
      if (gcount > 0 && !sb_off) chk("gap", gcount, CS_GAP);
      gcount = 0;
    end
    if (!busy) gcount = 0;
    else if (!spi_req && (prev_req || gcount > 0)) gcount++;
    if (spi_req && mcnt == SAMP) byte_in(spi_tx);
    if (rd_valid && !sb_off) begin
      rd_cnt++;
      if (exp_rd.size() == 0) chk("rd_extra", {24'd0, rd_data}, 32'h100);
      else chk("rd", rd_data, exp_rd.pop_front());
    end
    prev_req = spi_req;
  end

  task automatic push_addr(input logic [23:0] a);
    exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);
    exp_mosi.push_back(a[7:0]);
  endtask

  task automatic push_poll(input int polls);
    exp_mosi.push_back(OPC_RDSR);
    repeat (polls) exp_mosi.push_back(8'h00);
    exp_flen.push_back(1 + polls);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [23:0] a,
                        input logic [8:0] len, input bit eerr);
    int n, polls, cyc;
    n     = (len == 9'd0) ? 256 : int'(len);
    polls = stuck ? POLL_MAX : busy_cfg + 1;
    case (op)
      2'd0: begin
        exp_mosi.push_back(OPC_READ);
        push_addr(a);
        repeat (n) exp_mosi.push_back(8'h00);
        exp_flen.push_back(4 + n);
        for (int i = 0; i < n; i++)
          exp_rd.push_back(fget((int'(a) + i) & 'hFFFFFF));
      end
      2'd1: begin
        exp_mosi.push_back(OPC_WREN);
        exp_flen.push_back(1);
        exp_mosi.push_back(OPC_PP);
        push_addr(a);
        for (int i = 0; i < n; i++) exp_mosi.push_back(wq[i]);
        exp_flen.push_back(4 + n);
        push_poll(polls);
      end
      2'd2: begin
        exp_mosi.push_back(OPC_WREN);
        exp_flen.push_back(1);
        exp_mosi.push_back(OPC_SE);
        push_addr(a);
        exp_flen.push_back(4);
        push_poll(polls);
      end
      default: ;
    endcase
    req_seen = 0;
    rd_cnt   = 0;
    cyc      = 0;
    while (!cmd_ready && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = len;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2) cmd_valid = 1'b0;
    end while (!op_done && cyc < TMO);
    cmd_valid = 1'b0;
    chk("op_done", op_done, 1);
    chk("op_err", op_err, eerr);
    if (op == 2'd3) begin
      chk("rsvd_lat", cyc, 1);
      chk("rsvd_req", req_seen, 0);
    end
    @(negedge clk);
    chk("done_pulse", op_done, 0);
    chk("ready_back", cmd_ready, 1);
    if (op == 2'd0) chk("rd_cnt", rd_cnt, n);
    chk("sb_mosi", exp_mosi.size(), 0);
    chk("sb_rd", exp_rd.size(), 0);
    chk("sb_flen", exp_flen.size(), 0);
    wq.delete();
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", spi_req, 0);
    chk("rst_tx", spi_tx, 0);
    chk("rst_outs", {wr_ack, rd_valid, op_done, op_err}, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[24'h012345] = 8'hDE;
    mem[24'h012346] = 8'hAD;
    mem[24'h012347] = 8'hBE;
    mem[24'h012348] = 8'hEF;
    for (int i = 0; i < 4; i++) mem[24'h010000 + i] = 8'h11 * (i + 1);
    for (int i = 0; i < 256; i++) mem[24'h020000 + i] = 8'(i) ^ 8'h5A;

    run_op(2'd0, 24'h012345, 9'd4, 0);

    busy_cfg = 3;
    wq = '{8'hA5, 8'h5A};
    run_op(2'd1, 24'h000100, 9'd2, 0);
    chk("pp_mem0", fget(24'h000100), 8'hA5);
    chk("pp_mem1", fget(24'h000101), 8'h5A);
    run_op(2'd0, 24'h000100, 9'd2, 0);

    busy_cfg = 2;
    run_op(2'd2, 24'h010000, 9'd0, 0);
    chk("se_mem", fget(24'h010002), 8'hFF);
    run_op(2'd0, 24'h010000, 9'd4, 0);

    busy_cfg = 1;
    stuck    = 1;
    run_op(2'd2, 24'h010000, 9'd0, 1);
    stuck     = 0;
    busy_left = 0;

    busy_cfg = 0;
    run_op(2'd0, 24'h020000, 9'd0, 0);

    run_op(2'd3, 24'h000000, 9'd1, 1);

    busy_cfg = 1;
    wq = '{8'h01, 8'h02, 8'h03};
    run_op(2'd1, 24'h0300FE, 9'd3, 0);
    chk("pp_wrap", fget(24'h030000), 8'h03);
    run_op(2'd0, 24'h0300FE, 9'd2, 0);

    sb_off = 1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_addr  = 24'h012345;
    cmd_len   = 9'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!(spi_req && bidx == 3) && cyc < TMO) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("rst_wait", bidx, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", spi_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_mosi.delete();
    exp_rd.delete();
    exp_flen.delete();
    sb_off = 0;
    run_op(2'd0, 24'h012345, 9'd4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
